uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the core's single UART transmit line (tx_bit) between NUM_REQ byte-stream requesters, e.g. the CPU store path and a debug/trace unit.
- Round-robin arbitration with packet locking: once a requester's first byte is accepted, it owns the line until it sends a byte flagged last.
- Contains the 8N1 serializer and baud counter, so tx_bit drives the pin or the testbench loopback directly.

Parameters:
NUM_REQ, 2, number of requesters (2..8).
CLK_DIV, 868, clock cycles per UART bit (100 MHz / 115200); minimum 2.
DATA_W, 8, payload bits per frame; fixed at 8.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  NUM_REQ  requester i has a byte on req_data[i].
req_data  in  NUM_REQ x 8  byte per requester.
req_last  in  NUM_REQ  byte closes requester i's packet and releases the lock.
req_ready  out  NUM_REQ  byte accepted when req_valid[i] and req_ready[i] are both high on a clock edge.
tx_bit  out  1  serial line, idle high.
busy  out  1  high while a frame is in flight or a lock is held.
grant_id  out  clog2(NUM_REQ)  current or most recent owner.

Behaviour:
- Reset (asynchronous, any time including mid-frame):
  - tx_bit=1, req_ready=0, busy=0, grant_id=0.
  - Lock cleared; round-robin pointer set to 0; FSM to IDLE.
  - Any partial frame is abandoned; no resumption.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx_bit=1.
  - Accept -> START: shift register loaded with the byte, bit counter cleared.
  - START: tx_bit=0 for CLK_DIV cycles -> DATA.
  - DATA: bits sent LSB first, each held CLK_DIV cycles; after bit 7 -> STOP.
  - STOP: tx_bit=1 for CLK_DIV cycles -> IDLE.
- Timing:
  - tx_bit falls on the cycle after the accept edge.
  - One frame occupies 10*CLK_DIV cycles.
  - Back-to-back accepts are 10*CLK_DIV+1 cycles apart (one IDLE cycle between frames).
- req_ready is combinational and one-hot or zero. It is high only in IDLE:
  - When locked: only the owner's ready is high, whether or not its req_valid is high.
  - When unlocked: ready goes to the first requester with req_valid set, searching from (ptr+1) mod NUM_REQ upward with wrap.
  - No valid requester: all ready low.
- On accept:
  - grant_id <= winner; ptr <= winner.
  - lock <= ~req_last[winner]. last=1 on a single byte means a one-byte packet, so no lock is taken.
- While locked, other requesters wait indefinitely, even if the owner deasserts req_valid. There is no timeout.
- req_data is sampled only on the accept edge. Changes afterwards do not affect the frame in flight.
- Requesters must hold valid and data stable until accepted. Deasserting valid before accept withdraws the request with no side effects.
- busy = (state != IDLE) or lock.
- Baud counter counts 0..CLK_DIV-1 and resets on each state entry. No fractional divide.

Decomposition:
- Package uart_pkg:
  - tx_state_e enum (IDLE, START, DATA, STOP).
  - UART_DATA_W=8, UART_STOP_BITS=1.
  - Default CLK_DIV constant, shared with the future RX block.
- Sub-module uart_tx_engine (CLK_DIV parameter):
  - Interface: load/data in, ready/tx_bit out.
  - Contains the FSM, baud counter and shift register.
- uart_tx_arbiter contains the round-robin pick, lock, grant_id and the ready/valid mux.

Test Plan (CLK_DIV=4, NUM_REQ=2; tx_bit looped to an 8N1 bench monitor):
- Reset then idle, no requests -> tx_bit=1, busy=0, req_ready=00 for 100 cycles.
- Req0 sends 0xA5 with last=1 -> accept on cycle t; tx_bit=0 during t+1..t+4; then bits 1,0,1,0,0,1,0,1 at 4 cycles each; stop bit through t+40; monitor reads 0xA5; ready0 high again at t+41.
- Both requesters continuously valid, every byte last=1 -> grants alternate 0,1,0,1, starting with req1 since ptr=0 after reset; accepts spaced 41 cycles apart.
- Req0 sends 3-byte packet 0x11, 0x22, 0x33(last) while req1 is valid throughout -> req1 not granted until 0x33 is accepted; req0 stalls valid for 20 cycles mid-packet and req1 stays blocked; line decodes 11 22 33 then req1's byte.
- Reset asserted during DATA bit 3 of a frame -> tx_bit=1 immediately (asynchronously); busy=0; lock cleared; the next request is served cleanly and decodes correctly.
- Data changed after accept -> the transmitted byte equals the value sampled at the accept edge.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit path and the future receive block.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam int UART_DATA_W          = 8;
  localparam int UART_STOP_BITS       = 1;
  localparam int UART_CLK_DIV_DEFAULT = 868;

endpackage

// File: rtl/uart_tx_engine.sv
// 8N1 serializer: start bit, DATA_W bits LSB first, one stop bit, each CLK_DIV cycles.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int CLK_DIV = UART_CLK_DIV_DEFAULT,
  parameter int DATA_W  = UART_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              tx_bit
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int IDX_W = $clog2(DATA_W);

  tx_state_e         state, state_n;
  logic [CNT_W-1:0]  baud_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shreg;
  logic              baud_end;

  assign baud_end = (baud_cnt == CNT_W'(CLK_DIV - 1));

  always_comb begin
    state_n = state;
    ready   = 1'b0;
    tx_bit  = 1'b1;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (load) state_n = START;
      end
      START: begin
        tx_bit = 1'b0;
        if (baud_end) state_n = DATA;
      end
      DATA: begin
        tx_bit = shreg[0];
        if (baud_end && (bit_idx == IDX_W'(DATA_W - 1))) state_n = STOP;
      end
      STOP: begin
        if (baud_end) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Every bit period is exactly CLK_DIV long, so baud_end marks both bit and state boundaries.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE || baud_end) baud_cnt <= '0;
      else                           baud_cnt <= baud_cnt + 1'b1;
      if (state == IDLE)                 bit_idx <= '0;
      else if (state == DATA && baud_end) bit_idx <= bit_idx + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (state == IDLE && load)          shreg <= data;
    else if (state == DATA && baud_end) shreg <= shreg >> 1;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter sharing one UART transmit line among NUM_REQ byte streams.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int CLK_DIV = UART_CLK_DIV_DEFAULT,
  parameter int DATA_W  = UART_DATA_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_bit,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic              lock;
  logic              eng_ready;
  logic              accept;
  logic              pick_vld;
  logic [ID_W-1:0]   pick;
  logic [ID_W-1:0]   scan_idx;
  logic [ID_W-1:0]   win;
  logic [DATA_W-1:0] win_data;

  // The round-robin pointer always equals the last winner, so grant_id doubles as the pointer.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    scan_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      scan_idx = ID_W'((int'(grant_id) + k) % NUM_REQ);
      if (req_valid[scan_idx]) begin
        pick     = scan_idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (eng_ready && !reset) begin
      if (lock)          req_ready[grant_id] = 1'b1;
      else if (pick_vld) req_ready[pick]     = 1'b1;
    end
  end

  assign win      = lock ? grant_id : pick;
  assign accept   = |(req_ready & req_valid);
  assign win_data = req_data[int'(win)*DATA_W +: DATA_W];
  assign busy     = ~eng_ready | lock;

  // A byte flagged last on accept closes the packet; a lone last byte never takes the lock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock     <= 1'b0;
      grant_id <= '0;
    end else if (accept) begin
      grant_id <= win;
      lock     <= ~req_last[win];
    end
  end

  uart_tx_engine #(
    .CLK_DIV (CLK_DIV),
    .DATA_W  (DATA_W)
  ) u_engine (
    .clock  (clock),
    .reset  (reset),
    .load   (accept),
    .data   (win_data),
    .ready  (eng_ready),
    .tx_bit (tx_bit)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a frame-timing reference model and an 8N1 line monitor.
module tb_uart_tx_arbiter;

  localparam int NR    = 2;
  localparam int CD    = 4;
  localparam int FRAME = 10 * CD;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_data  = '0;
  logic [1:0]  req_last  = '0;
  logic [1:0]  req_ready;
  logic        tx_bit;
  logic        busy;
  logic [0:0]  grant_id;

  always #5 clock = ~clock;

  uart_tx_arbiter #(
    .NUM_REQ (NR),
    .CLK_DIV (CD),
    .DATA_W  (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_bit    (tx_bit),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  typedef struct {
    logic [7:0] d;
    bit         last;
    int         gap;
  } item_t;

  item_t q0[$];
  item_t q1[$];

  int total = 0;
  int bad   = 0;

  // Reference model: line occupancy from cycles since the last accept, plus lock/pointer.
  int         m_age   = 1000;
  bit         m_lock  = 0;
  int         m_ptr   = 0;
  int         m_grant = 0;
  logic [1:0] m_rdy   = '0;
  logic [7:0] m_cur   = '0;
  logic [1:0] acc_now = '0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input bit last, input int gap);
    item_t it;
    it.d = d;
    it.last = last;
    it.gap = gap;
    if (i == 0) q0.push_back(it);
    else        q1.push_back(it);
  endtask

  task automatic model_reset();
    m_age   = 1000;
    m_lock  = 0;
    m_ptr   = 0;
    m_grant = 0;
    m_rdy   = '0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    int    w;
    item_t it;
    acc_now = '0;
    if (reset) begin
      model_reset();
    end else begin
      acc_now = m_rdy & req_valid;
      if (acc_now != 0) begin
        w  = acc_now[1] ? 1 : 0;
        it = (w == 0) ? q0[0] : q1[0];
        m_grant = w;
        m_ptr   = w;
        m_lock  = !it.last;
        m_age   = 1;
        m_cur   = it.d;
        exp_q.push_back(it.d);
      end else if (m_age < 1000) begin
        m_age++;
      end
    end
  endtask

  task automatic drive();
    bit    have;
    item_t it;
    if (acc_now[0]) void'(q0.pop_front());
    if (acc_now[1]) void'(q1.pop_front());
    for (int i = 0; i < NR; i++) begin
      have = 0;
      if (i == 0 && q0.size() > 0) begin it = q0[0]; have = 1; end
      if (i == 1 && q1.size() > 0) begin it = q1[0]; have = 1; end
      if (have && it.gap > 0) begin
        have = 0;
        if (i == 0) q0[0].gap = it.gap - 1;
        else        q1[0].gap = it.gap - 1;
      end
      if (have && !reset) begin
        req_valid[i]        = 1'b1;
        req_data[i*8 +: 8]  = it.d;
        req_last[i]         = it.last;
      end else begin
        req_valid[i]        = 1'b0;
        req_data[i*8 +: 8]  = 8'($urandom);
        req_last[i]         = 1'($urandom);
      end
    end
  endtask

  task automatic expect_chk();
    logic [1:0] r;
    bit         infr;
    bit         found;
    int         slot;
    int         idx;
    logic       etx;
    infr  = !reset && m_age >= 1 && m_age <= FRAME;
    r     = '0;
    found = 0;
    if (!reset && !infr) begin
      if (m_lock) begin
        r[m_grant] = 1'b1;
      end else begin
        for (int k = 1; k <= NR; k++) begin
          idx = (m_ptr + k) % NR;
          if (!found && req_valid[idx]) begin
            r[idx] = 1'b1;
            found  = 1;
          end
        end
      end
    end
    m_rdy = r;
    etx = 1'b1;
    if (infr) begin
      slot = (m_age - 1) / CD;
      if (slot == 0)      etx = 1'b0;
      else if (slot <= 8) etx = m_cur[slot-1];
    end
    chk("tx_bit", tx_bit, etx);
    chk("busy", busy, infr || m_lock);
    chk("req_ready", req_ready, r);
    chk("grant_id", grant_id, m_grant);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    drive();
    @(negedge clock);
    expect_chk();
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((q0.size() != 0 || q1.size() != 0 || m_age <= FRAME + 1) && b < 6000) begin
      step();
      b++;
    end
    if (b >= 6000) chk("drain_timeout", b, 0);
    repeat (3) step();
  endtask

  // Independent 8N1 decoder on the line, sampling mid-bit.
  bit         mon_act  = 0;
  logic       mon_prev = 1'b1;
  int         mon_cnt  = 0;
  logic [7:0] mon_byte = '0;

  always @(negedge clock) begin
    if (reset) begin
      mon_act = 0;
    end else if (!mon_act) begin
      if (mon_prev && !tx_bit) begin
        mon_act = 1;
        mon_cnt = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % CD == 2 && mon_cnt / CD >= 1 && mon_cnt / CD <= 8)
        mon_byte[mon_cnt/CD-1] = tx_bit;
      if (mon_cnt == 9 * CD + 2) begin
        chk("stop_bit", tx_bit, 1);
        chk("mon_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("mon_byte", mon_byte, exp_q.pop_front());
        mon_act = 0;
      end
    end
    mon_prev = tx_bit;
  end

  initial begin
    int b;
    model_reset();
    drive();
    repeat (3) step();
    reset = 1'b0;
    repeat (100) step();

    push(0, 8'hA5, 1, 0);
    drain();

    for (int i = 0; i < 4; i++) begin
      push(0, 8'($urandom), 1, 0);
      push(1, 8'($urandom), 1, 0);
    end
    drain();

    // Owner's last byte is held back well past the previous frame while req1 waits.
    push(0, 8'h11, 0, 0);
    push(0, 8'h22, 0, 0);
    push(0, 8'h33, 1, 61);
    step();
    step();
    push(1, 8'h5C, 1, 0);
    drain();

    // Reset lands in DATA bit 3 (a zero bit) of a locked packet owned by req1.
    push(1, 8'h35, 0, 0);
    push(1, 8'h99, 1, 0);
    b = 0;
    do begin
      step();
      b++;
    end while (!(m_age == 18 && m_lock) && b < 200);
    if (b >= 200) chk("reset_wait", b, 0);
    #2;
    q0.delete();
    q1.delete();
    req_valid = '0;
    reset = 1'b1;
    #1;
    chk("async_tx", tx_bit, 1);
    chk("async_busy", busy, 0);
    chk("async_ready", req_ready, 0);
    chk("async_grant", grant_id, 0);
    model_reset();
    repeat (2) step();
    reset = 1'b0;
    push(0, 8'h0F, 1, 0);
    push(1, 8'h6B, 1, 0);
    drain();

    for (int p = 0; p < 10; p++) begin
      for (int i = 0; i < NR; i++) begin
        int len;
        len = $urandom_range(1, 3);
        for (int k = 0; k < len; k++)
          push(i, 8'($urandom), (k == len - 1), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 80) : 0);
      end
    end
    drain();

    chk("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
